// File: rtl/uart_rx_buffer.sv
// Receive-side byte FIFO feeding the core's `in` instruction.
// Bytes from the UART receiver are queued in a circular buffer and presented
// first-word-fall-through as a zero-extended byte or a little-endian word.
module uart_rx_buffer #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              in_word,
  input  logic              in_pop,
  input  logic              ovr_clr,
  output logic              Rx_ready,
  output logic [31:0]       in_data,
  output logic              overrun,
  output logic [ADDR_W:0]   fill_level
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic [ADDR_W:0]   cnt;

  logic              full;
  logic              pop_ok;
  logic              push_ok;
  logic              drop;
  logic [ADDR_W-1:0] rp_step;
  logic [ADDR_W:0]   cnt_add;
  logic [ADDR_W:0]   cnt_sub;

  // Availability, pop/push acceptance and pointer/count step sizes.
  always_comb begin
    full     = (cnt == (ADDR_W+1)'(DEPTH));
    Rx_ready = in_word ? (cnt >= (ADDR_W+1)'(4)) : (cnt >= (ADDR_W+1)'(1));
    pop_ok   = in_pop && Rx_ready;
    // A full buffer still takes the new byte when a pop frees space this cycle.
    push_ok  = rx_valid && (!full || pop_ok);
    drop     = rx_valid && full && !pop_ok;
    rp_step  = '0;
    cnt_sub  = '0;
    if (pop_ok) begin
      rp_step = in_word ? ADDR_W'(4) : ADDR_W'(1);
      cnt_sub = in_word ? (ADDR_W+1)'(4) : (ADDR_W+1)'(1);
    end
    cnt_add  = push_ok ? (ADDR_W+1)'(1) : '0;
  end

  // Operand presentation from the head of the queue; indices wrap naturally.
  always_comb begin
    in_data = {24'b0, mem[rp]};
    if (in_word) begin
      in_data = {mem[rp + ADDR_W'(3)], mem[rp + ADDR_W'(2)],
                 mem[rp + ADDR_W'(1)], mem[rp]};
    end
  end

  // Storage write; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wp] <= rx_byte;
    end
  end

  // Pointers, occupancy and sticky overrun flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) begin
        wp <= wp + ADDR_W'(1);
      end
      rp  <= rp + rp_step;
      cnt <= cnt + cnt_add - cnt_sub;
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign fill_level = cnt;

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
- Receive-side input buffer behind the UART receiver.
- Supplies the core's `in` instruction with data.
- Drives Rx_ready into the hazard unit; the decode stage stalls an `in` while Rx_ready is low.
- Queues received bytes in a circular FIFO and presents either one byte (zero-extended) or four bytes assembled into a little-endian word, first-word-fall-through, so decode sees the data in the same cycle it pops.

Parameters:
- ADDR_W, 8, log2 of FIFO depth in bytes (DEPTH = 2**ADDR_W = 256).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rstn  input  1  asynchronous, active-low reset
- rx_valid  input  1  one-cycle strobe from UART receiver: rx_byte is a new byte
- rx_byte  input  8  received byte
- in_word  input  1  width of the pending `in`: 1 = 32-bit word, 0 = byte
- in_pop  input  1  core consumes the `in` operand this cycle (InD1 and no other stall)
- ovr_clr  input  1  clears sticky overrun flag
- Rx_ready  output  1  enough bytes buffered for the requested width
- in_data  output  32  operand for the `in` instruction
- overrun  output  1  sticky: a byte was dropped because the FIFO was full
- fill_level  output  ADDR_W+1  bytes currently buffered (0..DEPTH)

Behaviour:
- Storage: DEPTH x 8 array. Write pointer wp and read pointer rp are ADDR_W bits, wrap modulo DEPTH. Count register cnt is ADDR_W+1 bits.
- Reset (rstn low, asynchronous):
  - wp = rp = cnt = 0, overrun = 0.
  - Rx_ready = 0, fill_level = 0.
  - Array contents are not reset.
  - Reset mid-operation discards all buffered bytes immediately.
- Rx_ready (combinational) = (in_word ? cnt >= 4 : cnt >= 1).
- in_data (combinational):
  - Byte mode: {24'b0, mem[rp]}.
  - Word mode: {mem[rp+3], mem[rp+2], mem[rp+1], mem[rp]}. Indices wrap modulo DEPTH. The first received byte lands in [7:0].
  - Value is don't-care when Rx_ready = 0.
- Pop:
  - Accepted when in_pop && Rx_ready.
  - rp advances by 1 (byte) or 4 (word), and cnt decreases by the same amount, on the next edge.
  - in_pop while Rx_ready = 0 is ignored with no state change.
- Push:
  - Accepted when rx_valid && (cnt < DEPTH || pop accepted this cycle).
  - Writes mem[wp] = rx_byte; wp += 1.
  - The new byte is visible to Rx_ready/in_data from the next cycle (no same-cycle bypass).
- Simultaneous push and pop: both take effect; cnt += 1 - popsize.
  - A full FIFO with an accepted pop also accepts the push.
- Overrun:
  - rx_valid with cnt == DEPTH and no accepted pop drops the byte; pointers and cnt are unchanged.
  - overrun is set to 1 on the next edge.
  - ovr_clr clears overrun. If ovr_clr and a drop happen in the same cycle, the set wins.
- Latency: byte at edge N (rx_valid high in cycle N-1) is poppable in cycle N.
- fill_level = cnt (registered).
- in_word may change every cycle; Rx_ready follows combinationally. Word mode with cnt = 1..3 holds Rx_ready = 0 (the core stalls) until the fourth byte arrives.
- No combinational path from rx_valid/rx_byte to any output.

Test Plan:
- Reset, then push 0x41 and assert in_word=0, in_pop=1 the following cycle -> Rx_ready=1, in_data=0x00000041; next cycle fill_level=0 and Rx_ready=0.
- Push 0x11, 0x22, 0x33 with in_word=1 -> Rx_ready=0 after each. Push 0x44 -> next cycle Rx_ready=1, in_data=0x44332211. Pop -> fill_level=0.
- Fill 256 bytes 0x00..0xFF, then push 0xAA with no pop -> byte dropped, overrun=1, fill_level=256. Pulse ovr_clr -> overrun=0.
- Full FIFO, then rx_valid=1 (byte 0xBB) with a byte pop in the same cycle -> in_data=0x00 popped, fill_level stays 256, and 0xBB is the last byte read after draining.
- Word read across wrap: make rp=254 by pushing/popping 254 bytes, push 0x01..0x04, word pop -> in_data=0x04030201, rp=2.
- Assert rstn low asynchronously mid-stream with 5 bytes buffered -> Rx_ready=0 and fill_level=0 immediately, without waiting for a clock edge. After release, the next pushed byte is the first one read.
